pdm_stereo_ctrl: RTL

- Sequences a stereo PDM microphone pair and the two cic3 decimators behind it.
- Generates the PDM microphone clock and demultiplexes the shared data line into left/right bit streams for the decimators.
- Holds the decimators in reset through mic wake-up, discards the settling frames, then pairs left/right PCM samples into stereo frames.
- Frames go out through a 2-entry buffer with a valid/ready handshake.

---
 rtl/pdm_stereo_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pdm_stereo_ctrl.sv
// Stereo PDM mic sequencer: clock generation, L/R bit demux, decimator wake/settle control, and stereo frame pairing.
// Optional macro PDM_STEREO_CTRL_DROP_CNT_EN adds a saturating drop_cnt output.
module pdm_stereo_ctrl #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned WAKE_CYCLES   = 1024,
  parameter int unsigned SETTLE_FRAMES = 4,
  parameter int unsigned PCM_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             pdm_clk,
  input  logic             pdm_data,
  output logic             cic_rst,
  output logic             l_bit,
  output logic             r_bit,
  output logic             bit_valid,
  input  logic [PCM_W-1:0] pcm_l,
  input  logic             pcm_l_valid,
  input  logic [PCM_W-1:0] pcm_r,
  input  logic             pcm_r_valid,
  output logic [PCM_W-1:0] frame_l,
  output logic [PCM_W-1:0] frame_r,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             overflow,
  output logic [1:0]       state
`ifdef PDM_STEREO_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned PER_W = $clog2(WAKE_CYCLES + 1);
  localparam int unsigned SET_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAKE   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               pdm_clk_q, pdm_clk_d;
  logic               cic_rst_q, cic_rst_d;
  logic               left_q, left_d;
  logic               l_bit_q, l_bit_d;
  logic               r_bit_q, r_bit_d;
  logic               bit_valid_q, bit_valid_d;
  logic [PCM_W-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               v0_q, v0_d, v1_q, v1_d;
  logic [PCM_W-1:0]   d0_l_q, d0_l_d, d0_r_q, d0_r_d;
  logic [PCM_W-1:0]   d1_l_q, d1_l_d, d1_r_q, d1_r_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_q, drop_d;
  logic               form;
  logic [PCM_W-1:0]   form_l;

  // Next-state logic: IDLE start, disable flush, capture, pairing, and per-state sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    set_d       = set_q;
    pdm_clk_d   = pdm_clk_q;
    cic_rst_d   = cic_rst_q;
    left_d      = left_q;
    l_bit_d     = l_bit_q;
    r_bit_d     = r_bit_q;
    bit_valid_d = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    d0_l_d      = d0_l_q;
    d0_r_d      = d0_r_q;
    d1_l_d      = d1_l_q;
    d1_r_d      = d1_r_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    form        = 1'b0;
    form_l      = hold_q;

    if (state_q == IDLE) begin
      if (enable) begin
        state_d   = WAKE;
        cnt_d     = '0;
        pdm_clk_d = 1'b1;
      end
    end else if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      per_d       = '0;
      set_d       = '0;
      pdm_clk_d   = 1'b0;
      cic_rst_d   = 1'b1;
      left_d      = 1'b0;
      l_bit_d     = 1'b0;
      r_bit_d     = 1'b0;
      hold_d      = '0;
      hold_full_d = 1'b0;
      v0_d        = 1'b0;
      v1_d        = 1'b0;
      d0_l_d      = '0;
      d0_r_d      = '0;
      d1_l_d      = '0;
      d1_r_d      = '0;
      overflow_d  = 1'b0;
      drop_d      = '0;
    end else begin
      cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      pdm_clk_d = (cnt_d < CNT_W'(HALF));
      if (cnt_q == CNT_MID) left_d = pdm_data;
      if (cnt_q == CNT_LAST) begin
        r_bit_d     = pdm_data;
        l_bit_d     = left_q;
        bit_valid_d = 1'b1;
      end

      // A right sample consumes a held left first; a same-cycle left then becomes the new hold.
      if (state_q != WAKE) begin
        if (pcm_r_valid && hold_full_q) begin
          form        = 1'b1;
          hold_full_d = pcm_l_valid;
          if (pcm_l_valid) hold_d = pcm_l;
        end else if (pcm_r_valid && pcm_l_valid) begin
          form   = 1'b1;
          form_l = pcm_l;
        end else if (pcm_l_valid) begin
          hold_d      = pcm_l;
          hold_full_d = 1'b1;
        end
      end

      case (state_q)
        WAKE: begin
          if (cnt_q == CNT_LAST) begin
            per_d = per_q + PER_W'(1);
            if (per_q + PER_W'(1) == PER_W'(WAKE_CYCLES)) begin
              state_d   = SETTLE;
              cic_rst_d = 1'b0;
              per_d     = '0;
            end
          end
        end
        SETTLE: begin
          if (SETTLE_FRAMES == 0) begin
            state_d = RUN;
          end else if (form) begin
            set_d = set_q + SET_W'(1);
            if (set_q + SET_W'(1) == SET_W'(SETTLE_FRAMES)) begin
              state_d = RUN;
              set_d   = '0;
            end
          end
        end
        RUN: begin
          // Pop shifts the tail into the head before the push is placed.
          if (v0_q && frame_ready) begin
            v0_d   = v1_q;
            d0_l_d = d1_l_q;
            d0_r_d = d1_r_q;
            v1_d   = 1'b0;
          end
          if (form) begin
            if (!v0_d) begin
              v0_d   = 1'b1;
              d0_l_d = form_l;
              d0_r_d = pcm_r;
            end else if (!v1_d) begin
              v1_d   = 1'b1;
              d1_l_d = form_l;
              d1_r_d = pcm_r;
            end else begin
              overflow_d = 1'b1;
              if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      set_q       <= '0;
      pdm_clk_q   <= 1'b0;
      cic_rst_q   <= 1'b1;
      left_q      <= 1'b0;
      l_bit_q     <= 1'b0;
      r_bit_q     <= 1'b0;
      bit_valid_q <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      d0_l_q      <= '0;
      d0_r_q      <= '0;
      d1_l_q      <= '0;
      d1_r_q      <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      set_q       <= set_d;
      pdm_clk_q   <= pdm_clk_d;
      cic_rst_q   <= cic_rst_d;
      left_q      <= left_d;
      l_bit_q     <= l_bit_d;
      r_bit_q     <= r_bit_d;
      bit_valid_q <= bit_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      d0_l_q      <= d0_l_d;
      d0_r_q      <= d0_r_d;
      d1_l_q      <= d1_l_d;
      d1_r_q      <= d1_r_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  assign pdm_clk     = pdm_clk_q;
  assign cic_rst     = cic_rst_q;
  assign l_bit       = l_bit_q;
  assign r_bit       = r_bit_q;
  assign bit_valid   = bit_valid_q;
  assign frame_l     = d0_l_q;
  assign frame_r     = d0_r_q;
  assign frame_valid = v0_q;
  assign overflow    = overflow_q;
  assign state       = state_q;

`ifdef PDM_STEREO_CTRL_DROP_CNT_EN
  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = ^drop_q;
`endif

endmodule
